// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 8-digit multiplexed hex display with frame-latched data; define LEADING_ZERO_BLANK_EN to darken leading zeros.
// Latency: SEG/AN registered one cycle after scan state; no backpressure, disp_load is always accepted.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 2000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] disp_data,
  input  logic        disp_load,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  digit_en,
  output logic [7:0]  SEG,
  output logic [7:0]  AN,
  output logic        frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [31:0]   pending;
  logic [31:0]   active;
  logic          pend_valid;
  logic          tc;
  logic          frame_end;
  logic [3:0]    nib;
  logic          show;
  logic [7:0]    seg_nxt;
  logic [7:0]    an_nxt;

  function automatic logic [6:0] font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0: f = 7'h40;
      4'h1: f = 7'h79;
      4'h2: f = 7'h24;
      4'h3: f = 7'h30;
      4'h4: f = 7'h19;
      4'h5: f = 7'h12;
      4'h6: f = 7'h02;
      4'h7: f = 7'h78;
      4'h8: f = 7'h00;
      4'h9: f = 7'h10;
      4'hA: f = 7'h08;
      4'hB: f = 7'h03;
      4'hC: f = 7'h46;
      4'hD: f = 7'h21;
      4'hE: f = 7'h06;
      default: f = 7'h0E;
    endcase
    return f;
  endfunction

  assign tc        = (presc == PW'(SCAN_DIV - 1));
  assign frame_end = tc && (idx == 3'd7);

`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0] msd;
`endif

  always_comb begin
    nib  = active[4*idx +: 4];
    show = digit_en[idx] && !(32'(presc) < BLANK_CYC);
`ifdef LEADING_ZERO_BLANK_EN
    // Highest non-zero nibble; digit 0 stays lit even when active is zero.
    msd = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (active[4*i +: 4] != 4'h0) msd = 3'(i);
    end
    if (idx > msd) show = 1'b0;
`endif
    seg_nxt = 8'hFF;
    an_nxt  = 8'hFF;
    if (show) begin
      seg_nxt = {~dp_mask[idx], font(nib)};
      an_nxt  = ~(8'h01 << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      presc      <= '0;
      idx        <= 3'd0;
      pending    <= 32'h0;
      active     <= 32'h0;
      pend_valid <= 1'b0;
      SEG        <= 8'hFF;
      AN         <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      presc      <= tc ? '0 : presc + PW'(1);
      if (tc) idx <= idx + 3'd1;
      frame_done <= frame_end;
      SEG        <= seg_nxt;
      AN         <= an_nxt;
      // Swap only at the frame boundary so a frame never mixes old and new nibbles.
      if (frame_end) begin
        if (disp_load)       active <= disp_data;
        else if (pend_valid) active <= pending;
        pend_valid <= 1'b0;
      end else if (disp_load) begin
        pending    <= disp_data;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed frames then random loads/masks, checked against a per-frame display model.
module tb_seg7_scan_driver;
  localparam int SD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] disp_data = 32'h0;
  logic        disp_load = 1'b0;
  logic [7:0]  dp_mask = 8'h00;
  logic [7:0]  digit_en = 8'hFF;
  logic [7:0]  SEG;
  logic [7:0]  AN;
  logic        frame_done;

  seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .RST(RST), .disp_data(disp_data), .disp_load(disp_load),
    .dp_mask(dp_mask), .digit_en(digit_en), .SEG(SEG), .AN(AN), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          k        = 0;
  logic [31:0] cur_val  = 32'h0;
  logic [31:0] next_val = 32'h0;
  logic        has_next = 1'b0;
  logic [7:0]  font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, k);
  endtask

  task automatic rst_cycle(input logic ld);
    RST = 1'b0;
    disp_load = ld;
    disp_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check("rst_seg", 32'(SEG), 32'hFF);
    check("rst_an", 32'(AN), 32'hFF);
    check("rst_fd", 32'(frame_done), 32'h0);
    k = 0;
    cur_val = 32'h0;
    has_next = 1'b0;
  endtask

  // One clock: after edge k the outputs show slot phase k%SD of digit (k/SD)%8 using the frame's value.
  task automatic step(input logic ld, input logic [31:0] dat, input logic [7:0] dpm, input logic [7:0] en);
    int         ph;
    int         d;
    int         nib;
    logic       lit;
    logic [7:0] es;
    logic [7:0] ea;
    RST = 1'b1;
    disp_load = ld;
    disp_data = dat;
    dp_mask = dpm;
    digit_en = en;
    @(posedge clk);
    #1;
    ph  = k % SD;
    d   = (k / SD) % 8;
    nib = int'((cur_val >> (4 * d)) & 32'hF);
    lit = (ph >= BC) && en[d];
`ifdef LEADING_ZERO_BLANK_EN
    if (d != 0 && (cur_val >> (4 * d)) == 32'h0) lit = 1'b0;
`endif
    es = lit ? {~dpm[d], font[nib][6:0]} : 8'hFF;
    ea = lit ? ~(8'h01 << d) : 8'hFF;
    check("seg", 32'(SEG), 32'(es));
    check("an", 32'(AN), 32'(ea));
    check("frame_done", 32'(frame_done), 32'((k % FRAME) == FRAME - 1));
    check("an_onehot", 32'($countones(~AN) <= 1), 32'h1);
    if (ld) begin
      next_val = dat;
      has_next = 1'b1;
    end
    if ((k % FRAME) == FRAME - 1) begin
      if (has_next) cur_val = next_val;
      has_next = 1'b0;
    end
    k++;
  endtask

  initial begin
    logic [31:0] rv;
    repeat (3) rst_cycle(1'b0);
    // Frame 0 loads, frame 1 shows 89ABCDEF.
    step(1'b1, 32'h89AB_CDEF, 8'h00, 8'hFF);
    repeat (63) step(1'b0, 32'h0, 8'h00, 8'hFF);
    // Tear check: 1s loaded in frame 2, 2s loaded mid frame 3 at digit 3.
    repeat (16) step(1'b0, 32'h0, 8'h00, 8'hFF);
    step(1'b1, 32'h1111_1111, 8'h00, 8'hFF);
    repeat (15) step(1'b0, 32'h0, 8'h00, 8'hFF);
    repeat (12) step(1'b0, 32'h0, 8'h00, 8'hFF);
    step(1'b1, 32'h2222_2222, 8'h00, 8'hFF);
    repeat (19) step(1'b0, 32'h0, 8'h00, 8'hFF);
    // Frame 4: stale pending 3, then a load on the boundary cycle wins.
    repeat (10) step(1'b0, 32'h0, 8'h00, 8'hFF);
    step(1'b1, 32'h0000_0003, 8'h00, 8'hFF);
    repeat (20) step(1'b0, 32'h0, 8'h00, 8'hFF);
    step(1'b1, 32'h5A5A_5A5A, 8'h00, 8'hFF);
    // Frame 5 shows 5A5A5A5A and loads zero.
    step(1'b1, 32'h0, 8'h00, 8'hFF);
    repeat (31) step(1'b0, 32'h0, 8'h00, 8'hFF);
    // Frame 6: value 0 with dp on digit 2 and digit 0 disabled; boundary loads A5.
    repeat (31) step(1'b0, 32'h0, 8'h04, 8'hFE);
    step(1'b1, 32'h0000_00A5, 8'h04, 8'hFE);
    repeat (32) step(1'b0, 32'h0, 8'h00, 8'hFF);
    // Random loads, masks and enables.
    repeat (320) begin
      rv = $urandom >> (4 * $urandom_range(0, 8));
      step(1'($urandom_range(0, 11) == 0), rv, 8'($urandom),
           ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom));
    end
    // Mid-frame reset with a pending load that must be discarded.
    repeat (5) step(1'b0, 32'h0, 8'h00, 8'hFF);
    step(1'b1, 32'h7777_7777, 8'h00, 8'hFF);
    rst_cycle(1'b1);
    repeat (64) step(1'b0, 32'h0, 8'h00, 8'hFF);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
